// File: rtl/icache_loader_if.sv
// ============================================================================
// icache_loader_if : byte-stream input and icache write-port bundle
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface icache_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  // master: byte source that also observes the icache write port
  modport master (
    output byte_data, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  // slave: the loader itself
  modport slave (
    input  byte_data, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

`default_nettype wire

// File: rtl/icache_loader.sv
// ============================================================================
// icache_loader : assembles a length-prefixed byte stream into 32-bit words,
//                 writes them to the icache and holds the core in reset until
//                 the image is complete. Optional macro: ICL_CHECKSUM_EN.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  icache_loader_if.slave    bus,
  output logic              core_rst_no,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W:0]   words_o
);

  localparam int unsigned       CAP      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   WORD_ONE = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
`ifdef ICL_CHECKSUM_EN
    ,S_CHK  = 3'd6
`endif
  } state_t;

  state_t            state_q;
  logic              byte_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic              core_rst_nq;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W:0]   n_q;
  logic [1:0]        cnt_q;
`ifdef ICL_CHECKSUM_EN
  logic [7:0]        xor_q;
  logic [7:0]        xor_d;
`endif

  logic              w_fire;
  logic              w_len_ok;
  logic [ADDR_W:0]   words_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [31:0]       wr_data_d;

  assign w_fire    = bus.byte_valid & byte_ready_q;
  assign w_len_ok  = (bus.byte_data != 8'd0) && ({24'd0, bus.byte_data} <= CAP);
  assign words_d   = words_q + WORD_ONE;
  assign wr_addr_d = wr_addr_q + ADDR_ONE;
  // little-endian assembly: the first byte ends up in [7:0] after four shifts
  assign wr_data_d = {bus.byte_data, wr_data_q[31:8]};
`ifdef ICL_CHECKSUM_EN
  assign xor_d     = xor_q ^ bus.byte_data;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_rst_nq  <= 1'b0;
      words_q      <= '0;
      n_q          <= '0;
      cnt_q        <= '0;
`ifdef ICL_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            state_q      <= S_LEN;
            byte_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_rst_nq  <= 1'b0;
            words_q      <= '0;
          end
        end

        S_LEN: begin
          if (w_fire) begin
            if (w_len_ok) begin
              // N fits in ADDR_W+1 bits once it has passed the range check
              n_q       <= (ADDR_W+1)'(bus.byte_data);
              cnt_q     <= '0;
              wr_addr_q <= '0;
`ifdef ICL_CHECKSUM_EN
              xor_q     <= '0;
`endif
              state_q   <= S_DATA;
            end else begin
              state_q      <= S_ERROR;
              byte_ready_q <= 1'b0;
              busy_q       <= 1'b0;
              error_q      <= 1'b1;
              core_rst_nq  <= 1'b0;
            end
          end
        end

        S_DATA: begin
          if (w_fire) begin
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_q + 2'd1;
`ifdef ICL_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
            if (cnt_q == 2'd3) begin
              state_q      <= S_WRITE;
              byte_ready_q <= 1'b0;
              wr_en_q      <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          words_q <= words_d;
          if (words_d == n_q) begin
`ifdef ICL_CHECKSUM_EN
            state_q      <= S_CHK;
            byte_ready_q <= 1'b1;
`else
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            core_rst_nq  <= 1'b1;
`endif
          end else begin
            wr_addr_q    <= wr_addr_d;
            state_q      <= S_DATA;
            byte_ready_q <= 1'b1;
          end
        end

`ifdef ICL_CHECKSUM_EN
        S_CHK: begin
          if (w_fire) begin
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            // written words stay in the icache even when the trailer is wrong
            if (bus.byte_data == xor_q) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              core_rst_nq <= 1'b1;
            end else begin
              state_q     <= S_ERROR;
              error_q     <= 1'b1;
              core_rst_nq <= 1'b0;
            end
          end
        end
`endif

        default: begin
          state_q      <= S_IDLE;
          byte_ready_q <= 1'b0;
          busy_q       <= 1'b0;
          core_rst_nq  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign core_rst_no    = core_rst_nq;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign words_o        = words_q;

endmodule

`default_nettype wire

// File: tb/tb_icache_loader.sv
// ============================================================================
// tb_icache_loader : randomized bench for icache_loader with a word-level
//                    reference model of the expected icache writes.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_loader;

  localparam int AW  = 6;
  localparam int CAP = 64;
`ifdef ICL_CHECKSUM_EN
  localparam bit CK_ON = 1'b1;
`else
  localparam bit CK_ON = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          core_rst_n, busy, done, error;
  logic [AW:0]   words;

  icache_loader_if #(.ADDR_W(AW)) bus ();

  icache_loader #(.ADDR_W(AW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .bus         (bus),
    .core_rst_no (core_rst_n),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .words_o     (words)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit tog     = 1'b0;

  logic [7:0]    pl[$];
  int unsigned   acc_q[$];
  logic [AW-1:0] mon_addr[$];
  logic [31:0]   mon_data[$];
  int unsigned   mon_cyc[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // every icache write is captured together with the cycle it appeared in
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.wr_en === 1'b1) begin
      mon_addr.push_back(bus.wr_addr);
      mon_data.push_back(bus.wr_data);
      mon_cyc.push_back(cyc);
      check_eq("ready_low_in_write", {63'd0, bus.byte_ready}, 64'd0);
      check_eq("busy_in_write", {63'd0, busy}, 64'd1);
    end
  end

  task automatic idle_inputs();
    bus.byte_valid = 1'b0;
    start          = 1'b0;
  endtask

  task automatic mon_clear();
    mon_addr.delete(); mon_data.delete(); mon_cyc.delete(); acc_q.delete();
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_ready"},    {63'd0, bus.byte_ready}, 64'd0);
    check_eq({pfx, "_wr_en"},    {63'd0, bus.wr_en},      64'd0);
    check_eq({pfx, "_wr_addr"},  {58'd0, bus.wr_addr},    64'd0);
    check_eq({pfx, "_wr_data"},  {32'd0, bus.wr_data},    64'd0);
    check_eq({pfx, "_busy"},     {63'd0, busy},           64'd0);
    check_eq({pfx, "_done"},     {63'd0, done},           64'd0);
    check_eq({pfx, "_error"},    {63'd0, error},          64'd0);
    check_eq({pfx, "_words"},    {57'd0, words},          64'd0);
    check_eq({pfx, "_core_rst"}, {63'd0, core_rst_n},     64'd0);
  endtask

  // mode 0: valid every cycle, 1: valid toggling, 2: random valid plus stray start pulses
  task automatic send_byte(input logic [7:0] b, input int mode, output int unsigned acc);
    bit sent = 1'b0;
    acc = 0;
    for (int k = 0; k < 200 && !sent; k++) begin
      @(negedge clk);
      case (mode)
        0:       bus.byte_valid = 1'b1;
        1:       begin tog = ~tog; bus.byte_valid = tog; end
        default: bus.byte_valid = ($urandom_range(0, 2) != 0);
      endcase
      start = (mode == 2) && ($urandom_range(0, 7) == 0);
      bus.byte_data = b;
      if (bus.byte_valid && bus.byte_ready) begin
        acc = cyc;
        @(posedge clk);
        sent = 1'b1;
      end
    end
    if (!sent) check_eq("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_session(input int n, input int mode, input bit bad_ck);
    int unsigned acc, exp_fin, fin_cyc;
    bit          fin    = 1'b0;
    bit          exp_ok = !bad_ck;
    logic [7:0]  x      = 8'd0;
    logic [31:0] exp_word;
    mon_clear();
    @(negedge clk); start = 1'b1; bus.byte_valid = 1'b0;
    @(negedge clk); start = 1'b0;
    check_eq("start_busy",     {63'd0, busy},           64'd1);
    check_eq("start_core_rst", {63'd0, core_rst_n},     64'd0);
    check_eq("start_done",     {63'd0, done},           64'd0);
    check_eq("start_error",    {63'd0, error},          64'd0);
    check_eq("start_words",    {57'd0, words},          64'd0);
    check_eq("start_ready",    {63'd0, bus.byte_ready}, 64'd1);
    send_byte(n[7:0], mode, acc);
    if (n < 1 || n > CAP) begin
      @(negedge clk); idle_inputs();
      check_eq("badlen_error",    {63'd0, error},          64'd1);
      check_eq("badlen_busy",     {63'd0, busy},           64'd0);
      check_eq("badlen_core_rst", {63'd0, core_rst_n},     64'd0);
      check_eq("badlen_ready",    {63'd0, bus.byte_ready}, 64'd0);
      repeat (3) @(negedge clk);
      check_eq("badlen_no_write", 64'(mon_data.size()), 64'd0);
      return;
    end
    for (int i = 0; i < 4 * n; i++) begin
      send_byte(pl[i], mode, acc);
      x ^= pl[i];
      if (i % 4 == 3) acc_q.push_back(acc);
    end
    exp_fin = acc + 2;
    if (CK_ON) begin
      send_byte(bad_ck ? (x ^ 8'h01) : x, mode, acc);
      exp_fin = acc + 1;
    end
    for (int k = 0; k < 20 && !fin; k++) begin
      @(negedge clk); idle_inputs();
      if (done || error) begin fin = 1'b1; fin_cyc = cyc; end
    end
    check_eq("finish_seen",    {63'd0, fin},            64'd1);
    check_eq("finish_latency", 64'(fin_cyc),            64'(exp_fin));
    check_eq("end_done",       {63'd0, done},           64'(exp_ok));
    check_eq("end_error",      {63'd0, error},          64'(!exp_ok));
    check_eq("end_core_rst",   {63'd0, core_rst_n},     64'(exp_ok));
    check_eq("end_busy",       {63'd0, busy},           64'd0);
    check_eq("end_ready",      {63'd0, bus.byte_ready}, 64'd0);
    check_eq("end_words",      {57'd0, words},          64'(n));
    check_eq("write_count",    64'(mon_data.size()),    64'(n));
    for (int i = 0; i < n && i < mon_data.size(); i++) begin
      exp_word = {pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]};
      check_eq("write_addr",    {58'd0, mon_addr[i]}, 64'(i));
      check_eq("write_data",    {32'd0, mon_data[i]}, {32'd0, exp_word});
      check_eq("write_latency", 64'(mon_cyc[i]),      64'(acc_q[i] + 1));
    end
  endtask

  task automatic fill_rand(input int nbytes);
    pl.delete();
    for (int i = 0; i < nbytes; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    int          n;
    int unsigned acc;
    idle_inputs();
    bus.byte_data = 8'd0;

    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("idle");

    pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'hA0, 8'h00};
    run_session(2, 0, 1'b0);
    if (mon_data.size() == 2) begin
      check_eq("plan_word0", {32'd0, mon_data[0]}, 64'h0000_0013);
      check_eq("plan_word1", {32'd0, mon_data[1]}, 64'h00A0_00B3);
    end
    run_session(2, 1, 1'b0);

    run_session(0, 0, 1'b0);
    run_session(65, 2, 1'b0);

    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    run_session(64, 2, 1'b0);
    if (mon_addr.size() == 64) check_eq("full_last_addr", {58'd0, mon_addr[63]}, 64'd63);

    for (int t = 0; t < 10; t++) begin
      n = (t == 3) ? $urandom_range(65, 255) : $urandom_range(1, 10);
      fill_rand(4 * n);
      run_session(n, $urandom_range(0, 2), CK_ON && ($urandom_range(0, 1) == 1));
    end

`ifdef ICL_CHECKSUM_EN
    pl = '{8'h01, 8'h02, 8'h04, 8'h08};
    run_session(1, 0, 1'b0);
    run_session(1, 0, 1'b1);
`endif

    // asynchronous abort part-way through the second word of a three-word image
    fill_rand(12);
    mon_clear();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    send_byte(8'd3, 0, acc);
    for (int i = 0; i < 6; i++) send_byte(pl[i], 0, acc);
    @(negedge clk); idle_inputs();
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    check_eq("abort_write_count", 64'(mon_data.size()), 64'd1);
    if (mon_data.size() == 1) begin
      check_eq("abort_write_addr", {58'd0, mon_addr[0]}, 64'd0);
      check_eq("abort_write_data", {32'd0, mon_data[0]}, {32'd0, pl[3], pl[2], pl[1], pl[0]});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("abort_no_more_writes", 64'(mon_data.size()), 64'd1);
    check_reset_vals("abort_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/icache_loader.md
Name: icache_loader

Overview:
- Writer side of the instruction cache. The core only reads the icache, through the word address (PC bits 7:2) and the instruction output.
- This block receives a program as a byte stream and assembles little-endian 32-bit words. It writes each word into the icache write port at sequential word addresses.
- It holds the core in reset while loading and releases it once the image is complete.
- It sits beside the icache at the top level. It drives the icache write port and the core's active-low reset.

Parameters:
- ADDR_W, 6, icache word-address width; capacity is 2^ADDR_W words (64 by default).

Ports:
- clk_i  in  1  system clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; begins a load session
- byte_i  in  8  stream byte
- byte_valid_i  in  1  byte_i valid
- byte_ready_o  out  1  loader accepts byte_i this cycle
- wr_en_o  out  1  icache write strobe, one cycle per word
- wr_addr_o  out  ADDR_W  icache word address
- wr_data_o  out  32  icache write data
- core_rst_no  out  1  active-low reset to the core
- busy_o  out  1  load session in progress
- done_o  out  1  last load completed successfully
- error_o  out  1  last load aborted
- words_o  out  ADDR_W+1  words written in current or last session

Behaviour:
- Reset (async, rst_ni=0): state IDLE. All outputs 0: byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, error_o, words_o. core_rst_no=0, so the core stays held until the first successful load.
- Handshake: a byte transfers on a rising edge where byte_valid_i & byte_ready_o. byte_ready_o is a registered function of state, high only in LEN, DATA and CHK. byte_valid_i may be held or dropped freely with no penalty.
- States:
  - IDLE: start_i -> LEN. busy_o=1, done_o=0, error_o=0, words_o=0, core_rst_no=0.
  - LEN: the accepted byte is word count N. If N==0 or N>2^ADDR_W -> ERROR. Otherwise store N, clear the byte counter and address -> DATA.
  - DATA: shift accepted bytes into wr_data_o, first byte into [7:0] and fourth into [31:24]. The 4th byte -> WRITE.
  - WRITE: one cycle, byte_ready_o=0.
    - wr_en_o=1 with the current wr_addr_o and wr_data_o.
    - words_o increments.
    - If words_o+1==N, go to CHK when the feature is enabled, otherwise DONE. Else advance wr_addr_o by 1 -> DATA.
  - DONE: busy_o=0, done_o=1, core_rst_no=1.
  - ERROR: busy_o=0, error_o=1, core_rst_no=0.
- Latency: 4th byte of a word accepted at edge t -> wr_en_o high during cycle t+1 only. The last word's WRITE cycle is followed by DONE one cycle later, with core_rst_no rising on the same edge as done_o.
- Address arithmetic: wr_addr_o increments mod 2^ADDR_W. The N check guarantees no wrap within a session. wr_addr_o holds its value after a write (no clear) until the next LEN.
- start_i in LEN, DATA, WRITE or CHK is ignored.
- start_i in DONE or ERROR starts a new session: core_rst_no=0 and done_o/error_o=0 on the next edge, state LEN.
- wr_en_o is never asserted outside WRITE.
- Partial words are never written. An abort via rst_ni mid-word discards the bytes; words already written remain in the icache.
- Async reset mid-session returns to IDLE immediately, with core_rst_no=0.

Optional Feature:
- Macro ICL_CHECKSUM_EN.
- Defined: after the last WRITE the state is CHK.
  - One further byte is accepted and compared to the XOR of all 4N payload bytes, accumulated as they are accepted; the N byte is excluded.
  - Match -> DONE. Mismatch -> ERROR, with core_rst_no kept 0. Words already written are not rolled back.
- Not defined: CHK state and XOR accumulator are absent; the last WRITE goes directly to DONE.

Test Plan:
- Reset then start_i; stream N=2, bytes 13 00 00 00 B3 00 A0 00, valid every cycle -> exactly two wr_en_o pulses:
  - addr 0, data 0x00000013
  - addr 1, data 0x00A000B3
  - then done_o=1, core_rst_no=1, words_o=2.
- The same stream with byte_valid_i toggled 1/0 each cycle -> identical write sequence and data; byte_ready_o=0 in every WRITE cycle.
- N=0, and separately N=65 with ADDR_W=6 -> ERROR on the next edge, error_o=1, no wr_en_o pulse, core_rst_no=0.
- Full 64-word image, bytes 0..255 repeating -> last write at addr 63, words_o=64, done_o=1. Then start_i -> core_rst_no=0 within one cycle and busy_o=1.
- rst_ni pulsed low after 6 payload bytes of N=3 -> immediate IDLE, with all outputs at reset values. One write has occurred at addr 0, and no write follows the reset.
- ICL_CHECKSUM_EN, N=1, bytes 01 02 04 08:
  - trailer 0x0F -> done_o=1.
  - trailer 0x0E -> error_o=1 and core_rst_no=0, with the one write at addr 0 still performed.
